// File: rtl/fifo_rtl.sv
// Single-clock FIFO with std/FWFT read modes, programmable almost flags and sticky error.
// Optional per-entry even parity is enabled by defining FIFO_PARITY_EN.
module fifo_rtl #(
    parameter int    DATA_WIDTH    = 32,
    parameter int    DEPTH         = 32,
    parameter string READ_MODE     = "fwft",
    parameter int    AFULL_THRESH  = DEPTH - 8,
    parameter int    AEMPTY_THRESH = 3,
    parameter int    CNT_WIDTH     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  afull,
    output logic [CNT_WIDTH-1:0]  wrcnt,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  aempty,
    output logic [CNT_WIDTH-1:0]  rdcnt,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  err
);
    localparam int AW   = $clog2(DEPTH);
    localparam bit FWFT = (READ_MODE == "fwft");
`ifdef FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam logic [AW:0]          PTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [MEM_W-1:0]     mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0] count, count_next;
    logic                 wr_acc, rd_acc, mem_has, mem_load, empty_next;
    logic [MEM_W-1:0]     wr_word, rd_word;

    assign wr_acc  = wen && !full;
    assign rd_acc  = ren && !empty;
    assign mem_has = (wr_ptr != rd_ptr);
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign wrcnt   = count;
    assign rdcnt   = count;

`ifdef FIFO_PARITY_EN
    assign wr_word = {^wdata, wdata};
`else
    assign wr_word = wdata;
`endif

    // In FWFT mode empty mirrors the output register, not count: the head
    // only becomes readable once it has been moved out of the memory.
    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc)
            count_next = count + CNT_ONE;
        else if (rd_acc && !wr_acc)
            count_next = count - CNT_ONE;
        if (FWFT) begin
            mem_load   = mem_has && (empty || rd_acc);
            empty_next = !(mem_load || (!empty && !rd_acc));
        end else begin
            mem_load   = rd_acc;
            empty_next = (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            afull     <= 1'b0;
            aempty    <= 1'b1;
            empty     <= 1'b1;
            rvalid    <= 1'b0;
            rdata     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            full      <= (count_next == CNT_WIDTH'(DEPTH));
            afull     <= (count_next >= CNT_WIDTH'(AFULL_THRESH));
            aempty    <= (count_next <= CNT_WIDTH'(AEMPTY_THRESH));
            empty     <= empty_next;
            rvalid    <= FWFT ? !empty_next : rd_acc;
            overflow  <= wen && full;
            underflow <= ren && empty;
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (mem_load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rdata  <= rd_word[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef FIFO_PARITY_EN
    // Checked one edge after the load, against the word now sitting in rdata.
    logic load_q, par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q <= 1'b0;
            par_q  <= 1'b0;
            err    <= 1'b0;
        end else begin
            load_q <= mem_load;
            if (mem_load)
                par_q <= rd_word[DATA_WIDTH];
            if (load_q && (^{par_q, rdata}))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
